// File: rtl/dac_sample_sched_if.sv
// Bundle of the sample-source, spi2dac and status signals around dac_sample_sched.
// Slot handshake: a sample moves when x_valid && x_ready on a rising edge; the source must hold x_data stable while x_valid is high.
interface dac_sample_sched_if #(
  parameter int DW = 10,
  parameter int CW = 8
);
  logic          tick;
  logic [1:0]    mode;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          spi_busy;
  logic [DW-1:0] dac_data;
  logic          dac_load;
  logic [1:0]    last_src;
  logic [CW-1:0] underrun_cnt;
  logic [CW-1:0] overrun_cnt;
  logic [1:0]    dbg_state;

  modport master (
    output tick, mode, a_valid, a_data, b_valid, b_data, spi_busy,
    input  a_ready, b_ready, dac_data, dac_load, last_src,
           underrun_cnt, overrun_cnt, dbg_state
  );

  modport slave (
    input  tick, mode, a_valid, a_data, b_valid, b_data, spi_busy,
    output a_ready, b_ready, dac_data, dac_load, last_src,
           underrun_cnt, overrun_cnt, dbg_state
  );
endinterface

// File: rtl/dac_sample_sched.sv
// Two-channel sample scheduler for the shared spi2dac path: one launch per tick,
// one pending sample per channel, underrun/overrun accounting.
module dac_sample_sched #(
  parameter int DW = 10,
  parameter int CW = 8
) (
  input  logic               sysclk,
  input  logic               rst,
  dac_sample_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ARM = 2'd2, XFER = 2'd3} state_t;

  localparam logic [1:0] SRC_A   = 2'd0;
  localparam logic [1:0] SRC_B   = 2'd1;
  localparam logic [1:0] SRC_MIX = 2'd2;
  localparam logic [1:0] SRC_REP = 2'd3;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state;
  logic          a_full, b_full;
  logic [DW-1:0] a_q, b_q;
  logic          rr_b;
  logic          take_a, take_b;
  logic [1:0]    arm_cnt;
  logic [DW-1:0] dac_q;
  logic          load_q;
  logic [1:0]    src_q;
  logic [CW-1:0] under_q, over_q;

  logic          sel_a, sel_b;
  logic [DW-1:0] sel_data;
  logic [1:0]    sel_src;
  logic          sel_rep;
  logic [DW-1:0] avg;

  // Sum is formed at DW+1 bits so 3FF+3FF averages to 3FF without overflow.
  assign avg = DW'(({1'b0, a_q} + {1'b0, b_q}) >> 1);

  always_comb begin
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    sel_data = dac_q;
    sel_src  = SRC_REP;
    case (bus.mode)
      2'd0: if (a_full) begin sel_a = 1'b1; sel_data = a_q; sel_src = SRC_A; end
      2'd1: if (b_full) begin sel_b = 1'b1; sel_data = b_q; sel_src = SRC_B; end
      2'd2: begin
        if (!rr_b && a_full)     begin sel_a = 1'b1; sel_data = a_q; sel_src = SRC_A; end
        else if (rr_b && b_full) begin sel_b = 1'b1; sel_data = b_q; sel_src = SRC_B; end
        else if (a_full)         begin sel_a = 1'b1; sel_data = a_q; sel_src = SRC_A; end
        else if (b_full)         begin sel_b = 1'b1; sel_data = b_q; sel_src = SRC_B; end
      end
      default: if (a_full && b_full) begin
        sel_a = 1'b1; sel_b = 1'b1; sel_data = avg; sel_src = SRC_MIX;
      end
    endcase
    sel_rep = (sel_src == SRC_REP);
  end

  // Selection is registered on the tick edge so dac_data and dac_load are valid together in LOAD;
  // the consumed slots are released on the edge leaving LOAD.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_full  <= 1'b0;
      b_full  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rr_b    <= 1'b0;
      take_a  <= 1'b0;
      take_b  <= 1'b0;
      arm_cnt <= '0;
      dac_q   <= '0;
      load_q  <= 1'b0;
      src_q   <= SRC_REP;
      under_q <= '0;
      over_q  <= '0;
    end else begin
      load_q <= 1'b0;
      if (bus.a_valid && !a_full) begin a_full <= 1'b1; a_q <= bus.a_data; end
      if (bus.b_valid && !b_full) begin b_full <= 1'b1; b_q <= bus.b_data; end
      if (bus.tick && state != IDLE && over_q != CNT_MAX) over_q <= over_q + CW'(1);
      case (state)
        IDLE: if (bus.tick) begin
          state  <= LOAD;
          load_q <= 1'b1;
          dac_q  <= sel_data;
          src_q  <= sel_src;
          take_a <= sel_a;
          take_b <= sel_b;
          if (sel_rep && under_q != CNT_MAX) under_q <= under_q + CW'(1);
          if (bus.mode == 2'd2 && !sel_rep) rr_b <= !rr_b;
        end
        LOAD: begin
          if (take_a) a_full <= 1'b0;
          if (take_b) b_full <= 1'b0;
          take_a  <= 1'b0;
          take_b  <= 1'b0;
          arm_cnt <= '0;
          state   <= ARM;
        end
        ARM: begin
          // Lost-start guard: give spi2dac four cycles to raise busy.
          if (bus.spi_busy)         state <= XFER;
          else if (arm_cnt == 2'd3) state <= IDLE;
          else                      arm_cnt <= arm_cnt + 2'd1;
        end
        XFER: if (!bus.spi_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready      = !a_full;
  assign bus.b_ready      = !b_full;
  assign bus.dac_data     = dac_q;
  assign bus.dac_load     = load_q;
  assign bus.last_src     = src_q;
  assign bus.underrun_cnt = under_q;
  assign bus.overrun_cnt  = over_q;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_dac_sample_sched.sv
// Directed bench for dac_sample_sched: slot handshake, mode selection, guards, counters and reset.
module tb_dac_sample_sched;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_ARM = 2'd2, S_XFER = 2'd3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   load_count;

  dac_sample_sched_if #(.DW(10), .CW(8)) bus ();

  dac_sample_sched #(.DW(10), .CW(8)) dut (
    .sysclk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (bus.dac_load === 1'b1) load_count++;

  // Driver tasks
  task automatic offer_a(input logic [9:0] d);
    @(posedge clk); #1 bus.a_valid = 1'b1; bus.a_data = d;
    @(posedge clk); #1 bus.a_valid = 1'b0;
  endtask

  task automatic offer_b(input logic [9:0] d);
    @(posedge clk); #1 bus.b_valid = 1'b1; bus.b_data = d;
    @(posedge clk); #1 bus.b_valid = 1'b0;
  endtask

  task automatic offer_both(input logic [9:0] da, input logic [9:0] db);
    @(posedge clk); #1 bus.a_valid = 1'b1; bus.a_data = da; bus.b_valid = 1'b1; bus.b_data = db;
    @(posedge clk); #1 bus.a_valid = 1'b0; bus.b_valid = 1'b0;
  endtask

  // Ends at the falling edge inside the LOAD cycle.
  task automatic pulse_tick();
    @(posedge clk); #1 bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && bus.dbg_state !== S_IDLE; i++) @(negedge clk);
    checks++;
    if (bus.dbg_state !== S_IDLE) begin
      errors++; $display("FAIL %s: state %0d after timeout, required IDLE", name, bus.dbg_state);
    end
  endtask

  task automatic busy_window(input int n);
    @(posedge clk); #1 bus.spi_busy = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.spi_busy = 1'b0;
    wait_idle("busy_window_idle");
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %b want 1", bus.a_ready); end
    checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %b want 1", bus.b_ready); end
    checks++; if (bus.dac_data !== 10'h000) begin errors++; $display("FAIL rst_dac_data: got %h want 000", bus.dac_data); end
    checks++; if (bus.dac_load !== 1'b0) begin errors++; $display("FAIL rst_dac_load: got %b want 0", bus.dac_load); end
    checks++; if (bus.last_src !== 2'd3) begin errors++; $display("FAIL rst_last_src: got %0d want 3", bus.last_src); end
    checks++; if (bus.underrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_underrun: got %0d want 0", bus.underrun_cnt); end
    checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL rst_overrun: got %0d want 0", bus.overrun_cnt); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", bus.dbg_state); end
  endtask

  task automatic test_mode0();
    bus.mode = 2'd0;
    offer_a(10'h155);
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL m0_a_full: got %b want 0", bus.a_ready); end
    checks++; if (bus.dac_load !== 1'b0) begin errors++; $display("FAIL m0_no_early_load: got %b want 0", bus.dac_load); end
    pulse_tick();
    checks++; if (bus.dac_load !== 1'b1) begin errors++; $display("FAIL m0_load: got %b want 1", bus.dac_load); end
    checks++; if (bus.dac_data !== 10'h155) begin errors++; $display("FAIL m0_data: got %h want 155", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd0) begin errors++; $display("FAIL m0_src: got %0d want 0", bus.last_src); end
    checks++; if (bus.dbg_state !== S_LOAD) begin errors++; $display("FAIL m0_state_load: got %0d want 1", bus.dbg_state); end
    @(negedge clk);
    checks++; if (bus.dac_load !== 1'b0) begin errors++; $display("FAIL m0_load_width: got %b want 0", bus.dac_load); end
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL m0_a_freed: got %b want 1", bus.a_ready); end
    checks++; if (bus.dbg_state !== S_ARM) begin errors++; $display("FAIL m0_state_arm: got %0d want 2", bus.dbg_state); end
    @(posedge clk); #1 bus.spi_busy = 1'b1;
    repeat (33) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_XFER) begin errors++; $display("FAIL m0_state_xfer: got %0d want 3", bus.dbg_state); end
    checks++; if (bus.dac_data !== 10'h155) begin errors++; $display("FAIL m0_data_hold: got %h want 155", bus.dac_data); end
    @(posedge clk); #1 bus.spi_busy = 1'b0;
    wait_idle("m0_return_idle");
  endtask

  task automatic test_round_robin();
    bus.mode = 2'd2;
    offer_both(10'h100, 10'h200);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h100) begin errors++; $display("FAIL rr_first_data: got %h want 100", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd0) begin errors++; $display("FAIL rr_first_src: got %0d want 0", bus.last_src); end
    busy_window(5);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h200) begin errors++; $display("FAIL rr_second_data: got %h want 200", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd1) begin errors++; $display("FAIL rr_second_src: got %0d want 1", bus.last_src); end
    checks++; if (bus.underrun_cnt !== 8'd0) begin errors++; $display("FAIL rr_no_underrun: got %0d want 0", bus.underrun_cnt); end
    busy_window(5);
    pulse_tick();
    checks++; if (bus.dac_load !== 1'b1) begin errors++; $display("FAIL rr_repeat_load: got %b want 1", bus.dac_load); end
    checks++; if (bus.dac_data !== 10'h200) begin errors++; $display("FAIL rr_repeat_data: got %h want 200", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd3) begin errors++; $display("FAIL rr_repeat_src: got %0d want 3", bus.last_src); end
    checks++; if (bus.underrun_cnt !== 8'd1) begin errors++; $display("FAIL rr_underrun: got %0d want 1", bus.underrun_cnt); end
    busy_window(5);
  endtask

  task automatic test_average();
    bus.mode = 2'd3;
    offer_both(10'h3FF, 10'h3FF);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h3FF) begin errors++; $display("FAIL avg_max_data: got %h want 3ff", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd2) begin errors++; $display("FAIL avg_max_src: got %0d want 2", bus.last_src); end
    @(negedge clk);
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) begin errors++; $display("FAIL avg_both_freed: got %b want 11", {bus.a_ready, bus.b_ready}); end
    busy_window(5);
    offer_a(10'h0AA);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h3FF) begin errors++; $display("FAIL avg_rep_data: got %h want 3ff", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd3) begin errors++; $display("FAIL avg_rep_src: got %0d want 3", bus.last_src); end
    checks++; if (bus.underrun_cnt !== 8'd2) begin errors++; $display("FAIL avg_underrun: got %0d want 2", bus.underrun_cnt); end
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL avg_a_kept: got %b want 0", bus.a_ready); end
    busy_window(5);
    offer_b(10'h155);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h0FF) begin errors++; $display("FAIL avg_mix_data: got %h want 0ff", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd2) begin errors++; $display("FAIL avg_mix_src: got %0d want 2", bus.last_src); end
    busy_window(5);
  endtask

  task automatic test_overrun();
    int base;
    bus.mode = 2'd0;
    pulse_tick();
    checks++; if (bus.last_src !== 2'd3) begin errors++; $display("FAIL ov_rep_src: got %0d want 3", bus.last_src); end
    checks++; if (bus.underrun_cnt !== 8'd3) begin errors++; $display("FAIL ov_underrun: got %0d want 3", bus.underrun_cnt); end
    @(posedge clk); #1 bus.spi_busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_XFER) begin errors++; $display("FAIL ov_in_xfer: got %0d want 3", bus.dbg_state); end
    base = load_count;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1 bus.tick = 1'b1;
      @(posedge clk); #1 bus.tick = 1'b0;
    end
    @(negedge clk);
    checks++; if (bus.overrun_cnt !== 8'd255) begin errors++; $display("FAIL ov_saturate: got %0d want 255", bus.overrun_cnt); end
    checks++; if (load_count !== base) begin errors++; $display("FAIL ov_no_extra_load: got %0d want %0d", load_count, base); end
    checks++; if (bus.dbg_state !== S_XFER) begin errors++; $display("FAIL ov_fsm_unaffected: got %0d want 3", bus.dbg_state); end
    @(posedge clk); #1 bus.spi_busy = 1'b0;
    wait_idle("ov_return_idle");
  endtask

  task automatic test_lost_start();
    bus.mode = 2'd0;
    offer_a(10'h2AB);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h2AB) begin errors++; $display("FAIL ls_data: got %h want 2ab", bus.dac_data); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.dbg_state !== S_ARM) begin errors++; $display("FAIL ls_arm_%0d: got %0d want 2", k, bus.dbg_state); end
    end
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL ls_timeout_idle: got %0d want 0", bus.dbg_state); end
    offer_a(10'h123);
    pulse_tick();
    checks++; if (bus.dac_load !== 1'b1) begin errors++; $display("FAIL ls_next_load: got %b want 1", bus.dac_load); end
    checks++; if (bus.dac_data !== 10'h123) begin errors++; $display("FAIL ls_next_data: got %h want 123", bus.dac_data); end
    checks++; if (bus.overrun_cnt !== 8'd255) begin errors++; $display("FAIL ls_overrun_hold: got %0d want 255", bus.overrun_cnt); end
    busy_window(5);
  endtask

  task automatic test_reset_mid_xfer();
    bus.mode = 2'd2;
    offer_both(10'h011, 10'h022);
    pulse_tick();
    checks++; if (bus.dac_data !== 10'h011) begin errors++; $display("FAIL rm_data: got %h want 011", bus.dac_data); end
    @(posedge clk); #1 bus.spi_busy = 1'b1;
    offer_a(10'h033);
    @(negedge clk);
    checks++; if (bus.dbg_state !== S_XFER) begin errors++; $display("FAIL rm_in_xfer: got %0d want 3", bus.dbg_state); end
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL rm_both_full: got %b want 00", {bus.a_ready, bus.b_ready}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) begin errors++; $display("FAIL rm_ready: got %b want 11", {bus.a_ready, bus.b_ready}); end
    checks++; if (bus.dac_data !== 10'h000) begin errors++; $display("FAIL rm_dac_data: got %h want 000", bus.dac_data); end
    checks++; if (bus.last_src !== 2'd3) begin errors++; $display("FAIL rm_last_src: got %0d want 3", bus.last_src); end
    checks++; if (bus.underrun_cnt !== 8'd0) begin errors++; $display("FAIL rm_underrun: got %0d want 0", bus.underrun_cnt); end
    checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL rm_overrun: got %0d want 0", bus.overrun_cnt); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL rm_state: got %0d want 0", bus.dbg_state); end
    bus.spi_busy = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; load_count = 0;
    rst = 1'b1;
    bus.tick = 1'b0; bus.mode = 2'd0; bus.spi_busy = 1'b0;
    bus.a_valid = 1'b0; bus.a_data = '0; bus.b_valid = 1'b0; bus.b_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_mode0();
    test_round_robin();
    test_average();
    test_overrun();
    test_lost_start();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_sample_sched.md
Name: dac_sample_sched

Overview:
- Schedules 10-bit samples from two requesters (channel A, channel B) onto the single shared SPI DAC path (spi2dac).
- Holds one pending sample per channel and launches one DAC transfer per sample tick from clktick.
- Tracks the transfer handshake with spi2dac and counts underruns and overruns.
- Sits between the sample sources and spi2dac in the top level; the tick comes from the existing clktick instance.

Parameters:
- DW, 10, sample width (matches spi2dac data input)
- CW, 8, width of underrun/overrun counters

Ports:
- sysclk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle sample strobe from clktick
- mode  in  2  0=A only, 1=B only, 2=round-robin A/B, 3=average of A and B
- a_valid  in  1  channel A sample offered
- a_data  in  DW  channel A sample
- a_ready  out  1  channel A slot empty
- b_valid  in  1  channel B sample offered
- b_data  in  DW  channel B sample
- b_ready  out  1  channel B slot empty
- spi_busy  in  1  spi2dac transfer in progress (CS low)
- dac_data  out  DW  sample presented to spi2dac, held stable between loads
- dac_load  out  1  one-cycle launch strobe to spi2dac
- last_src  out  2  source of the last launched sample: 0=A, 1=B, 2=mix, 3=repeat
- underrun_cnt  out  CW  saturating count of ticks with required data missing
- overrun_cnt  out  CW  saturating count of ticks dropped while busy

Behaviour:
- Reset values: a_ready=1, b_ready=1, both slots empty, dac_data=0, dac_load=0, last_src=3, both counters 0, state IDLE, rr pointer=A. Reset mid-transfer aborts the sequence immediately; the spi2dac state is not touched.
- Slots: x_ready = slot empty. A handshake occurs when x_valid & x_ready; data is captured that edge and x_ready drops next cycle. The slot frees in the cycle after the LOAD that consumes it. A slot consumed in LOAD can accept a new sample no earlier than the next cycle. There is no combinational path from the valid inputs to the ready outputs.
- FSM states: IDLE, LOAD, ARM, XFER.
  - IDLE: on tick, go to LOAD. Without tick, stay.
  - LOAD: select the sample, register dac_data, pulse dac_load for exactly this one cycle, then go to ARM.
  - ARM: wait for spi_busy=1, then go to XFER. If spi_busy is not seen within 4 cycles, return to IDLE (lost-start guard).
  - XFER: wait for spi_busy=0, then go to IDLE.
- Tick in LOAD, ARM or XFER: the tick is dropped, overrun_cnt increments (saturating), and the FSM is unaffected. Tick in IDLE is never counted as overrun.
- Selection in LOAD, by mode:
  - mode 0: use slot A if full; otherwise repeat the previous dac_data and count an underrun.
  - mode 1: same as mode 0, using slot B.
  - mode 2: use the channel at the rr pointer if its slot is full, else the other channel if its slot is full, else repeat and count an underrun. The pointer toggles to the other channel after a successful non-repeat launch.
  - mode 3: requires both slots full. dac_data = (a+b)>>1, computed at DW+1 bits, no overflow; both slots are consumed. If either slot is empty, repeat, count an underrun, and consume nothing.
- A repeat still pulses dac_load (the DAC is refreshed) and sets last_src=3.
- Slots not selected in a LOAD keep their contents.
- A mode change takes effect at the next LOAD. Stale samples in slots are not flushed.
- Counters saturate at 2^CW-1 and never wrap.
- Latency: tick in IDLE → dac_load high 1 cycle later (the LOAD cycle after the tick edge).

Test Plan:
- Reset, then mode 0, a_data=10'h155 offered, tick → dac_load 1 cycle after tick, dac_data=155, last_src=0, a_ready back to 1. Drive spi_busy high for 34 cycles → FSM returns to IDLE.
- Mode 2, both slots full (A=100, B=200), three ticks spaced past each busy window → launches 100, 200, then repeat 200 with last_src=3 and underrun_cnt=1.
- Mode 3, A=10'h3FF, B=10'h3FF → dac_data=3FF. With only A full → repeat, underrun_cnt increments, and slot A is still full afterward.
- Tick asserted during XFER, 300 times → overrun_cnt=255 (saturated), and no extra dac_load pulses.
- spi_busy held low after LOAD → back to IDLE after 4 ARM cycles. The next tick then launches normally.
- rst asserted during XFER with both slots full → all outputs return to reset values asynchronously, and a_ready=b_ready=1.
